// File: rtl/jpeg_rle_vli_encoder.sv
// ----------------------------------------------------------------------------
// jpeg_rle_vli_encoder
//
// Entropy front-end of the JPEG encode path. Takes one 8x8 block of quantised
// DCT coefficients in zigzag order (64 per block), applies DC differential
// prediction, run-length codes the AC zeros (ZRL / EOB) and emits one
// Run/Size symbol with its VLI amplitude bits per output slot.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   i_coeff_valid  coefficient present
//   o_coeff_ready  coefficient accepted when valid & ready
//   i_coeff_value  signed 12-bit coefficient; block position is implicit
//   i_dc_clear     with coefficient 0 only: use predictor 0 for this block
//   o_sym_valid    symbol present
//   i_sym_ready    downstream accepts the symbol
//   o_sym_rs       {run[3:0], size[3:0]}
//   o_sym_amp      VLI amplitude bits, LSB-aligned, size bits wide
//   o_sym_is_dc    symbol carries the DC difference
//   o_sym_last     final symbol of the block (EOB or coefficient 63)
// ----------------------------------------------------------------------------
module jpeg_rle_vli_encoder (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_coeff_valid,
   output logic               o_coeff_ready,
   input  logic signed [11:0] i_coeff_value,
   input  logic               i_dc_clear,
   output logic               o_sym_valid,
   input  logic               i_sym_ready,
   output logic [7:0]         o_sym_rs,
   output logic [10:0]        o_sym_amp,
   output logic               o_sym_is_dc,
   output logic               o_sym_last
);

   localparam logic [0:0] S_IN  = 1'b0;
   localparam logic [0:0] S_ZRL = 1'b1;

   // Block state
   logic [0:0]         r_state;
   logic [5:0]         r_idx;
   logic [5:0]         r_run;
   logic signed [11:0] r_dc_pred;
   logic signed [11:0] r_pend_val;
   logic               r_pend_last;
   logic [1:0]         r_zrl_left;

   // Output register
   logic               r_sym_valid;
   logic [7:0]         r_sym_rs;
   logic [10:0]        r_sym_amp;
   logic               r_sym_is_dc;
   logic               r_sym_last;

   logic [0:0]         w_state_nxt;
   logic [5:0]         w_idx_nxt;
   logic [5:0]         w_run_nxt;
   logic signed [11:0] w_dc_pred_nxt;
   logic signed [11:0] w_pend_val_nxt;
   logic               w_pend_last_nxt;
   logic [1:0]         w_zrl_left_nxt;

   logic               w_out_free;
   logic               w_accept;
   logic signed [12:0] w_diff13;
   logic signed [11:0] w_dc_diff;
   logic signed [11:0] w_ac_clip;
   logic signed [11:0] w_enc_val;
   logic [10:0]        w_mag;
   logic [3:0]         w_size;
   logic [10:0]        w_amp_raw;
   logic [10:0]        w_amp;

   logic               w_emit;
   logic [7:0]         w_rs;
   logic [10:0]        w_amp_o;
   logic               w_is_dc;
   logic               w_last;

   // The output slot is free when empty or being drained this cycle.
   assign w_out_free    = ~r_sym_valid | i_sym_ready;
   assign o_coeff_ready = (r_state == S_IN) & w_out_free;
   assign w_accept      = i_coeff_valid & o_coeff_ready;

   // DC difference in 13 bits, saturated to +/-2047 so size never exceeds 11.
   assign w_diff13 = {i_coeff_value[11], i_coeff_value}
                   - (i_dc_clear ? 13'sd0 : {r_dc_pred[11], r_dc_pred});

   always_comb begin
      if (w_diff13 > 13'sd2047) begin
         w_dc_diff = 12'sd2047;
      end else if (w_diff13 < -13'sd2047) begin
         w_dc_diff = -12'sd2047;
      end else begin
         w_dc_diff = w_diff13[11:0];
      end
   end

   always_comb begin
      if (i_coeff_value > 12'sd1023) begin
         w_ac_clip = 12'sd1023;
      end else if (i_coeff_value < -12'sd1023) begin
         w_ac_clip = -12'sd1023;
      end else begin
         w_ac_clip = i_coeff_value;
      end
   end

   // One shared size/VLI encoder; the held value wins while draining ZRLs.
   always_comb begin
      if (r_state == S_ZRL) begin
         w_enc_val = r_pend_val;
      end else if (r_idx == 6'd0) begin
         w_enc_val = w_dc_diff;
      end else begin
         w_enc_val = w_ac_clip;
      end
   end

   // Magnitude fits 11 bits because -2048 can never reach the encoder.
   assign w_mag = w_enc_val[11] ? (~w_enc_val[10:0] + 11'd1) : w_enc_val[10:0];

   always_comb begin
      w_size = 4'd0;
      for (int i = 0; i < 11; i++) begin
         if (w_mag[i]) begin
            w_size = 4'(i + 1);
         end
      end
   end

   // Negative values send the low bits of v-1 (one's complement of |v|).
   assign w_amp_raw = w_enc_val[11] ? (w_enc_val[10:0] - 11'd1) : w_enc_val[10:0];
   assign w_amp     = w_amp_raw & ~(11'h7FF << w_size);

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_run_nxt       = r_run;
      w_dc_pred_nxt   = r_dc_pred;
      w_pend_val_nxt  = r_pend_val;
      w_pend_last_nxt = r_pend_last;
      w_zrl_left_nxt  = r_zrl_left;
      w_emit          = 1'b0;
      w_rs            = 8'h00;
      w_amp_o         = 11'd0;
      w_is_dc         = 1'b0;
      w_last          = 1'b0;

      if (r_state == S_ZRL) begin
         if (w_out_free) begin
            w_emit = 1'b1;
            if (r_zrl_left != 2'd0) begin
               w_rs           = 8'hF0;
               w_zrl_left_nxt = r_zrl_left - 2'd1;
            end else begin
               w_rs        = {r_run[3:0], w_size};
               w_amp_o     = w_amp;
               w_last      = r_pend_last;
               w_run_nxt   = 6'd0;
               w_state_nxt = S_IN;
            end
         end
      end else if (w_accept) begin
         w_idx_nxt = r_idx + 6'd1;
         if (r_idx == 6'd0) begin
            w_emit        = 1'b1;
            w_rs          = {4'h0, w_size};
            w_amp_o       = w_amp;
            w_is_dc       = 1'b1;
            w_dc_pred_nxt = i_coeff_value;
            w_run_nxt     = 6'd0;
         end else if (w_ac_clip == 12'sd0) begin
            if (r_idx == 6'd63) begin
               // EOB; any trailing zero run is simply dropped.
               w_emit    = 1'b1;
               w_last    = 1'b1;
               w_run_nxt = 6'd0;
            end else begin
               w_run_nxt = r_run + 6'd1;
            end
         end else if (r_run < 6'd16) begin
            w_emit    = 1'b1;
            w_rs      = {r_run[3:0], w_size};
            w_amp_o   = w_amp;
            w_last    = (r_idx == 6'd63);
            w_run_nxt = 6'd0;
         end else begin
            // First ZRL goes out now; the rest plus the held value follow.
            w_emit          = 1'b1;
            w_rs            = 8'hF0;
            w_zrl_left_nxt  = r_run[5:4] - 2'd1;
            w_pend_val_nxt  = w_ac_clip;
            w_pend_last_nxt = (r_idx == 6'd63);
            w_state_nxt     = S_ZRL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IN;
         r_idx       <= 6'd0;
         r_run       <= 6'd0;
         r_dc_pred   <= 12'sd0;
         r_pend_val  <= 12'sd0;
         r_pend_last <= 1'b0;
         r_zrl_left  <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_run       <= w_run_nxt;
         r_dc_pred   <= w_dc_pred_nxt;
         r_pend_val  <= w_pend_val_nxt;
         r_pend_last <= w_pend_last_nxt;
         r_zrl_left  <= w_zrl_left_nxt;
      end
   end

   // Output register holds while stalled and reloads without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sym_valid <= 1'b0;
         r_sym_rs    <= 8'h00;
         r_sym_amp   <= 11'd0;
         r_sym_is_dc <= 1'b0;
         r_sym_last  <= 1'b0;
      end else if (w_out_free) begin
         r_sym_valid <= w_emit;
         if (w_emit) begin
            r_sym_rs    <= w_rs;
            r_sym_amp   <= w_amp_o;
            r_sym_is_dc <= w_is_dc;
            r_sym_last  <= w_last;
         end
      end
   end

   assign o_sym_valid = r_sym_valid;
   assign o_sym_rs    = r_sym_rs;
   assign o_sym_amp   = r_sym_amp;
   assign o_sym_is_dc = r_sym_is_dc;
   assign o_sym_last  = r_sym_last;

endmodule

// File: tb/tb_jpeg_rle_vli_encoder.sv
// ----------------------------------------------------------------------------
// tb_jpeg_rle_vli_encoder
//
// Directed, table-driven bench. Each table row describes one block (DC value,
// dc_clear, at most one nonzero AC coefficient, ready pattern) and the symbol
// list expected from it, worked out by hand. A reset-mid-block sequence and
// output-stall stability checks are handled separately.
// ----------------------------------------------------------------------------
module tb_jpeg_rle_vli_encoder;

   logic               clk;
   logic               rst_n;
   logic               i_coeff_valid;
   logic               o_coeff_ready;
   logic signed [11:0] i_coeff_value;
   logic               i_dc_clear;
   logic               o_sym_valid;
   logic               i_sym_ready;
   logic [7:0]         o_sym_rs;
   logic [10:0]        o_sym_amp;
   logic               o_sym_is_dc;
   logic               o_sym_last;

   jpeg_rle_vli_encoder u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_coeff_valid (i_coeff_valid),
      .o_coeff_ready (o_coeff_ready),
      .i_coeff_value (i_coeff_value),
      .i_dc_clear    (i_dc_clear),
      .o_sym_valid   (o_sym_valid),
      .i_sym_ready   (i_sym_ready),
      .o_sym_rs      (o_sym_rs),
      .o_sym_amp     (o_sym_amp),
      .o_sym_is_dc   (o_sym_is_dc),
      .o_sym_last    (o_sym_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [11:0] dc;
      logic               clr;
      int                 pos;        // AC index of the nonzero value, 0 = none
      logic signed [11:0] val;
      logic               rnd;        // random sym_ready
      int                 exp_stall;  // coeff_ready-low cycles, -1 = unchecked
      int                 nsym;
      logic [7:0][7:0]    rs;
      logic [7:0][10:0]   amp;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs[NVEC];

   int tests = 0;
   int fails = 0;

   logic [7:0]  got_rs[$];
   logic [10:0] got_amp[$];
   logic        got_dc[$];
   logic        got_last[$];

   task automatic set_vec(input int i, input logic signed [11:0] dc, input logic clr,
                          input int pos, input logic signed [11:0] val, input logic rnd,
                          input int exp_stall);
      vecs[i].dc        = dc;
      vecs[i].clr       = clr;
      vecs[i].pos       = pos;
      vecs[i].val       = val;
      vecs[i].rnd       = rnd;
      vecs[i].exp_stall = exp_stall;
      vecs[i].nsym      = 0;
      vecs[i].rs        = '0;
      vecs[i].amp       = '0;
   endtask

   task automatic add_sym(input int i, input logic [7:0] rs, input logic [10:0] amp);
      vecs[i].rs[vecs[i].nsym]  = rs;
      vecs[i].amp[vecs[i].nsym] = amp;
      vecs[i].nsym              = vecs[i].nsym + 1;
   endtask

   // Drives up to max_acc coefficients of one block, collecting symbols.
   task automatic drive_block(input vec_t v, input int max_acc, output int stalls);
      int          sent;
      int          cyc;
      logic        prev_stall;
      logic [7:0]  p_rs;
      logic [10:0] p_amp;
      logic        p_dc;
      logic        p_last;
      sent       = 0;
      cyc        = 0;
      stalls     = 0;
      prev_stall = 1'b0;
      p_rs       = '0;
      p_amp      = '0;
      p_dc       = 1'b0;
      p_last     = 1'b0;
      got_rs.delete();
      got_amp.delete();
      got_dc.delete();
      got_last.delete();
      while (1'b1) begin
         @(negedge clk);
         if (prev_stall) begin
            tests++;
            if (o_sym_valid !== 1'b1 || o_sym_rs !== p_rs || o_sym_amp !== p_amp ||
                o_sym_is_dc !== p_dc || o_sym_last !== p_last) begin
               fails++;
               $display("FAIL stall_hold: got v=%0b rs=%02h amp=%03h dc=%0b last=%0b, want v=1 rs=%02h amp=%03h dc=%0b last=%0b",
                        o_sym_valid, o_sym_rs, o_sym_amp, o_sym_is_dc, o_sym_last,
                        p_rs, p_amp, p_dc, p_last);
            end
         end
         if (sent >= max_acc && (max_acc < 64 || !o_sym_valid)) break;
         if (cyc >= 1000) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d coefficients accepted, want %0d", sent, max_acc);
            break;
         end
         i_sym_ready   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         i_coeff_valid = (sent < max_acc);
         i_coeff_value = (sent == 0) ? v.dc : ((sent == v.pos) ? v.val : 12'sd0);
         // dc_clear held high on AC coefficients; it must have no effect there.
         i_dc_clear    = (sent == 0) ? v.clr : 1'b1;
         #1;
         if (o_sym_valid && i_sym_ready) begin
            got_rs.push_back(o_sym_rs);
            got_amp.push_back(o_sym_amp);
            got_dc.push_back(o_sym_is_dc);
            got_last.push_back(o_sym_last);
         end
         if (o_sym_valid && !i_sym_ready) begin
            tests++;
            if (o_coeff_ready !== 1'b0) begin
               fails++;
               $display("FAIL stall_ready: got coeff_ready=%0b, want 0", o_coeff_ready);
            end
            prev_stall = 1'b1;
            p_rs       = o_sym_rs;
            p_amp      = o_sym_amp;
            p_dc       = o_sym_is_dc;
            p_last     = o_sym_last;
         end else begin
            prev_stall = 1'b0;
         end
         if (i_coeff_valid && !o_coeff_ready) stalls++;
         if (i_coeff_valid && o_coeff_ready) sent++;
         cyc++;
      end
      i_coeff_valid = 1'b0;
      i_dc_clear    = 1'b0;
   endtask

   task automatic check_block(input int b, input int stalls);
      vec_t v;
      int   n;
      v = vecs[b];
      n = got_rs.size();
      tests++;
      if (n != v.nsym) begin
         fails++;
         $display("FAIL blk%0d sym_count: got %0d, want %0d", b, n, v.nsym);
      end
      for (int i = 0; i < v.nsym && i < n; i++) begin
         tests++;
         if (got_rs[i] !== v.rs[i] || got_amp[i] !== v.amp[i] ||
             got_dc[i] !== (i == 0) || got_last[i] !== (i == v.nsym - 1)) begin
            fails++;
            $display("FAIL blk%0d sym%0d: got rs=%02h amp=%03h dc=%0b last=%0b, want rs=%02h amp=%03h dc=%0b last=%0b",
                     b, i, got_rs[i], got_amp[i], got_dc[i], got_last[i],
                     v.rs[i], v.amp[i], (i == 0), (i == v.nsym - 1));
         end
      end
      if (!v.rnd && v.exp_stall >= 0) begin
         tests++;
         if (stalls != v.exp_stall) begin
            fails++;
            $display("FAIL blk%0d zrl_stall: got %0d cycles, want %0d", b, stalls, v.exp_stall);
         end
      end
   endtask

   initial begin
      int stalls;

      // Predictor carries between rows, so row order matters.
      set_vec(0, 12'sd5, 1'b0, 0, 12'sd0, 1'b0, 0);          // diff +5
      add_sym(0, 8'h03, 11'h005);  add_sym(0, 8'h00, 11'h000);
      set_vec(1, -12'sd3, 1'b0, 0, 12'sd0, 1'b0, 0);         // diff -8
      add_sym(1, 8'h04, 11'h007);  add_sym(1, 8'h00, 11'h000);
      set_vec(2, 12'sd0, 1'b1, 2, -12'sd1, 1'b0, 0);         // run 1, -1
      add_sym(2, 8'h00, 11'h000);  add_sym(2, 8'h11, 11'h000);  add_sym(2, 8'h00, 11'h000);
      set_vec(3, 12'sd0, 1'b0, 35, 12'sd3, 1'b0, 2);         // run 34
      add_sym(3, 8'h00, 11'h000);  add_sym(3, 8'hF0, 11'h000);  add_sym(3, 8'hF0, 11'h000);
      add_sym(3, 8'h22, 11'h003);  add_sym(3, 8'h00, 11'h000);
      set_vec(4, 12'sd0, 1'b0, 63, 12'sd1, 1'b0, -1);        // run 62, last coeff
      add_sym(4, 8'h00, 11'h000);  add_sym(4, 8'hF0, 11'h000);  add_sym(4, 8'hF0, 11'h000);
      add_sym(4, 8'hF0, 11'h000);  add_sym(4, 8'hE1, 11'h001);
      set_vec(5, 12'sd0, 1'b0, 1, 12'sd1500, 1'b1, -1);      // clip to +1023
      add_sym(5, 8'h00, 11'h000);  add_sym(5, 8'h0A, 11'h3FF);  add_sym(5, 8'h00, 11'h000);
      set_vec(6, 12'sd0, 1'b0, 1, -12'sd1023, 1'b1, -1);
      add_sym(6, 8'h00, 11'h000);  add_sym(6, 8'h0A, 11'h000);  add_sym(6, 8'h00, 11'h000);
      set_vec(7, 12'sd100, 1'b0, 0, 12'sd0, 1'b1, -1);       // diff +100
      add_sym(7, 8'h07, 11'h064);  add_sym(7, 8'h00, 11'h000);
      set_vec(8, 12'sd7, 1'b1, 0, 12'sd0, 1'b1, -1);         // dc_clear after 100
      add_sym(8, 8'h03, 11'h007);  add_sym(8, 8'h00, 11'h000);
      set_vec(9, -12'sd2048, 1'b0, 16, -12'sd5, 1'b0, 0);    // diff -2055 sat, run 15
      add_sym(9, 8'h0B, 11'h000);  add_sym(9, 8'hF3, 11'h002);  add_sym(9, 8'h00, 11'h000);
      set_vec(10, 12'sd2047, 1'b0, 17, 12'sd1, 1'b0, 1);     // diff 4095 sat, run 16
      add_sym(10, 8'h0B, 11'h7FF); add_sym(10, 8'hF0, 11'h000); add_sym(10, 8'h01, 11'h001);
      add_sym(10, 8'h00, 11'h000);
      set_vec(11, 12'sd2047, 1'b0, 20, 12'sd6, 1'b1, -1);    // ZRL under backpressure
      add_sym(11, 8'h00, 11'h000); add_sym(11, 8'hF0, 11'h000); add_sym(11, 8'h33, 11'h006);
      add_sym(11, 8'h00, 11'h000);
      set_vec(12, 12'sd4, 1'b0, 0, 12'sd0, 1'b0, 0);         // after mid-block reset
      add_sym(12, 8'h03, 11'h004); add_sym(12, 8'h00, 11'h000);

      rst_n         = 1'b0;
      i_coeff_valid = 1'b0;
      i_coeff_value = 12'sd0;
      i_dc_clear    = 1'b0;
      i_sym_ready   = 1'b0;
      #3;
      tests++;
      if (o_sym_valid !== 1'b0 || o_sym_rs !== 8'h00 || o_sym_amp !== 11'd0 ||
          o_sym_is_dc !== 1'b0 || o_sym_last !== 1'b0 || o_coeff_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: got v=%0b rs=%02h amp=%03h dc=%0b last=%0b crdy=%0b, want 0 00 000 0 0 1",
                  o_sym_valid, o_sym_rs, o_sym_amp, o_sym_is_dc, o_sym_last, o_coeff_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int b = 0; b < NVEC - 1; b++) begin
         drive_block(vecs[b], 64, stalls);
         check_block(b, stalls);
      end

      // Mid-block reset: 21 coefficients of a DC=9 block, then reset.
      set_vec(NVEC - 1 + 0, 12'sd4, 1'b0, 0, 12'sd0, 1'b0, 0);
      add_sym(12, 8'h03, 11'h004); add_sym(12, 8'h00, 11'h000);
      begin
         vec_t part;
         part     = vecs[12];
         part.dc  = 12'sd9;
         part.pos = 5;
         part.val = 12'sd2;
         drive_block(part, 21, stalls);
      end
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         tests++;
         if (o_sym_valid !== 1'b0 || o_coeff_ready !== 1'b1) begin
            fails++;
            $display("FAIL in_reset: got sym_valid=%0b coeff_ready=%0b, want 0 1",
                     o_sym_valid, o_coeff_ready);
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      drive_block(vecs[12], 64, stalls);
      check_block(12, stalls);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
